// File: rtl/cursor_pkg.sv
// Shared VT52 cursor command encodings: opcodes, display modes, scroll direction.
// Also used by the upstream escape-sequence decoder.
package cursor_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_SET   = 4'd1,
      OP_UP    = 4'd2,
      OP_DOWN  = 4'd3,
      OP_LEFT  = 4'd4,
      OP_RIGHT = 4'd5,
      OP_HOME  = 4'd6,
      OP_CR    = 4'd7,
      OP_LF    = 4'd8,
      OP_RI    = 4'd9,
      OP_TAB   = 4'd10,
      OP_ADV   = 4'd11
   } cursor_op_e;

   typedef enum logic [1:0] {
      MODE_BLINK      = 2'd0,
      MODE_STEADY     = 2'd1,
      MODE_HIDDEN     = 2'd2,
      MODE_HIDDEN_ALT = 2'd3
   } cursor_mode_e;

   typedef enum logic {
      SCROLL_UP   = 1'b0,
      SCROLL_DOWN = 1'b1
   } scroll_dir_e;

   typedef enum logic {
      S_IDLE,
      S_SCROLL_WAIT
   } pos_state_e;

   // Opcodes 12-15 are reserved and behave as NOP, so they must not restart the blink.
   function automatic logic op_restarts_blink(input logic [3:0] op);
      return (op != OP_NOP) && (op <= OP_ADV);
   endfunction

endpackage

// File: rtl/cursor_blink_timer.sv
// Frame-counted blink phase: counts vblank rising edges, toggles phase on wrap,
// and restarts solid (phase=1, count=0) on request, which takes priority over an edge.
module cursor_blink_timer
   import cursor_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 32
)(
   input  logic clk,
   input  logic reset,
   input  logic i_vblank,
   input  logic i_restart,
   output logic o_phase
);

   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic             r_vblank_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;
   logic             w_rise;

   assign w_rise  = i_vblank & ~r_vblank_d;
   assign o_phase = r_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vblank_d <= 1'b0;
         r_cnt      <= '0;
         r_phase    <= 1'b1;
      end else begin
         r_vblank_d <= i_vblank;
         if (i_restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
         end else if (w_rise) begin
            if (r_cnt == CNT_LAST) begin
               r_cnt   <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/cursor_ctrl.sv
// VT52 cursor controller: position update from decoded commands, scroll request
// handshake with the scroll engine, and registered blink/visibility outputs.
module cursor_ctrl
   import cursor_pkg::*;
#(
   parameter int unsigned ROW_BITS     = 5,
   parameter int unsigned COL_BITS     = 7,
   parameter int unsigned ROWS         = 24,
   parameter int unsigned COLS         = 80,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter int unsigned TAB_STOP     = 8
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                vblank,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_op,
   input  logic [COL_BITS-1:0] cmd_x,
   input  logic [ROW_BITS-1:0] cmd_y,
   input  logic [1:0]          mode,
   output logic [COL_BITS-1:0] cursor_x,
   output logic [ROW_BITS-1:0] cursor_y,
   output logic                cursor_visible,
   output logic                scroll_req,
   output logic                scroll_dir,
   input  logic                scroll_ack,
   output logic                led
);

   // One bit of headroom so +1 / tab arithmetic cannot alias before clamping.
   localparam int unsigned XW = COL_BITS + 1;
   localparam int unsigned YW = ROW_BITS + 1;
   localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);
   localparam logic [XW-1:0] TAB_MASK = ~XW'(TAB_STOP - 1);
   localparam logic [XW-1:0] TAB_STEP = XW'(TAB_STOP);

   pos_state_e          r_state;
   logic [COL_BITS-1:0] r_x;
   logic [ROW_BITS-1:0] r_y;
   logic                r_scroll_req;
   logic                r_scroll_dir;
   logic                r_visible;
   logic                r_led;

   logic [XW-1:0] w_xw, w_x_inc, w_x_tab, w_x_set, w_x_nx;
   logic [YW-1:0] w_yw, w_y_inc, w_y_set, w_y_nx;
   logic          w_scroll;
   logic          w_dir;
   logic          w_accept;
   logic          w_restart;
   logic          w_phase;

   assign cmd_ready      = ~r_scroll_req;
   assign w_accept       = cmd_valid & ~r_scroll_req;
   assign w_restart      = w_accept & op_restarts_blink(cmd_op);
   assign cursor_x       = r_x;
   assign cursor_y       = r_y;
   assign scroll_req     = r_scroll_req;
   assign scroll_dir     = r_scroll_dir;
   assign cursor_visible = r_visible;
   assign led            = r_led;

   always_comb begin
      w_xw     = {1'b0, r_x};
      w_yw     = {1'b0, r_y};
      w_x_inc  = w_xw + XW'(1);
      w_y_inc  = w_yw + YW'(1);
      w_x_tab  = (w_xw & TAB_MASK) + TAB_STEP;
      w_x_set  = {1'b0, cmd_x};
      w_y_set  = {1'b0, cmd_y};
      w_x_nx   = w_xw;
      w_y_nx   = w_yw;
      w_scroll = 1'b0;
      w_dir    = SCROLL_UP;
      case (cmd_op)
         OP_SET: begin
            w_x_nx = (w_x_set > X_MAX) ? X_MAX : w_x_set;
            w_y_nx = (w_y_set > Y_MAX) ? Y_MAX : w_y_set;
         end
         OP_UP:    if (w_yw != '0) w_y_nx = w_yw - YW'(1);
         OP_DOWN:  w_y_nx = (w_y_inc > Y_MAX) ? Y_MAX : w_y_inc;
         OP_LEFT:  if (w_xw != '0) w_x_nx = w_xw - XW'(1);
         OP_RIGHT,
         OP_ADV:   w_x_nx = (w_x_inc > X_MAX) ? X_MAX : w_x_inc;
         OP_HOME: begin
            w_x_nx = '0;
            w_y_nx = '0;
         end
         OP_CR:    w_x_nx = '0;
         OP_LF: begin
            if (w_yw >= Y_MAX) begin
               w_scroll = 1'b1;
               w_dir    = SCROLL_UP;
            end else begin
               w_y_nx = w_y_inc;
            end
         end
         OP_RI: begin
            if (w_yw == '0) begin
               w_scroll = 1'b1;
               w_dir    = SCROLL_DOWN;
            end else begin
               w_y_nx = w_yw - YW'(1);
            end
         end
         OP_TAB:   w_x_nx = (w_x_tab > X_MAX) ? X_MAX : w_x_tab;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_scroll_req <= 1'b0;
         r_scroll_dir <= SCROLL_UP;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x <= w_x_nx[COL_BITS-1:0];
                  r_y <= w_y_nx[ROW_BITS-1:0];
                  if (w_scroll) begin
                     r_state      <= S_SCROLL_WAIT;
                     r_scroll_req <= 1'b1;
                     r_scroll_dir <= w_dir;
                  end
               end
            end
            S_SCROLL_WAIT: begin
               if (scroll_ack) begin
                  r_state      <= S_IDLE;
                  r_scroll_req <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_scroll_req <= 1'b0;
            end
         endcase
      end
   end

   cursor_blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk       (clk),
      .reset     (reset),
      .i_vblank  (vblank),
      .i_restart (w_restart),
      .o_phase   (w_phase)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_visible <= 1'b0;
         r_led     <= 1'b0;
      end else begin
         case (mode)
            MODE_BLINK:  r_visible <= w_phase;
            MODE_STEADY: r_visible <= 1'b1;
            default:     r_visible <= 1'b0;
         endcase
         r_led <= r_visible;
      end
   end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl: constant vector table, directed scroll/blink
// sequences, and randomized traffic against an integer reference model.
module tb_cursor_ctrl;
   import cursor_pkg::*;

   localparam int TB_BF = 2;
   localparam int TB_ROWS = 24;
   localparam int TB_COLS = 80;
   localparam int TB_TAB = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       vblank;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [6:0] cmd_x;
   logic [4:0] cmd_y;
   logic [1:0] mode;
   logic [6:0] cursor_x;
   logic [4:0] cursor_y;
   logic       cursor_visible;
   logic       scroll_req;
   logic       scroll_dir;
   logic       scroll_ack;
   logic       led;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_x, m_y, m_req, m_dir, m_phase, m_cnt, m_vis, m_led, m_vprev;

   typedef struct {
      int op;
      int x;
      int y;
      int ex;
      int ey;
   } vec_t;

   vec_t tbl[22];

   cursor_ctrl #(
      .ROW_BITS(5), .COL_BITS(7), .ROWS(TB_ROWS), .COLS(TB_COLS),
      .BLINK_FRAMES(TB_BF), .TAB_STOP(TB_TAB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .vblank         (vblank),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_x          (cmd_x),
      .cmd_y          (cmd_y),
      .mode           (mode),
      .cursor_x       (cursor_x),
      .cursor_y       (cursor_y),
      .cursor_visible (cursor_visible),
      .scroll_req     (scroll_req),
      .scroll_dir     (scroll_dir),
      .scroll_ack     (scroll_ack),
      .led            (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Cursor movement rules in plain integer terms.
   task automatic model_apply(input int op, input int cx, input int cy);
      case (op)
         1:  begin m_x = imin(cx, TB_COLS-1); m_y = imin(cy, TB_ROWS-1); end
         2:  if (m_y > 0) m_y--;
         3:  if (m_y < TB_ROWS-1) m_y++;
         4:  if (m_x > 0) m_x--;
         5, 11: if (m_x < TB_COLS-1) m_x++;
         6:  begin m_x = 0; m_y = 0; end
         7:  m_x = 0;
         8:  if (m_y == TB_ROWS-1) begin m_req = 1; m_dir = 0; end else m_y++;
         9:  if (m_y == 0) begin m_req = 1; m_dir = 1; end else m_y--;
         10: m_x = imin((m_x / TB_TAB + 1) * TB_TAB, TB_COLS-1);
         default: ;
      endcase
   endtask

   task automatic model_step();
      int acc;
      int op;
      int rise;
      if (reset) begin
         m_x = 0; m_y = 0; m_req = 0; m_dir = 0;
         m_phase = 1; m_cnt = 0; m_vis = 0; m_led = 0; m_vprev = 0;
      end else begin
         op   = int'(cmd_op);
         acc  = (cmd_valid && m_req == 0) ? 1 : 0;
         m_led = m_vis;
         m_vis = (mode == 2'd0) ? m_phase : ((mode == 2'd1) ? 1 : 0);
         rise = (vblank && m_vprev == 0) ? 1 : 0;
         m_vprev = vblank ? 1 : 0;
         if (acc == 1 && op >= 1 && op <= 11) begin
            m_cnt = 0;
            m_phase = 1;
         end else if (rise == 1) begin
            m_cnt++;
            if (m_cnt == TB_BF) begin
               m_cnt = 0;
               m_phase = 1 - m_phase;
            end
         end
         if (m_req == 1) begin
            if (scroll_ack) m_req = 0;
         end else if (acc == 1) begin
            model_apply(op, int'(cmd_x), int'(cmd_y));
         end
      end
   endtask

   task automatic check_all();
      chk("cursor_x", int'(cursor_x), m_x);
      chk("cursor_y", int'(cursor_y), m_y);
      chk("scroll_req", int'(scroll_req), m_req);
      if (m_req == 1) chk("scroll_dir", int'(scroll_dir), m_dir);
      chk("cmd_ready", int'(cmd_ready), 1 - m_req);
      chk("cursor_visible", int'(cursor_visible), m_vis);
      chk("led", int'(led), m_led);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic issue(input cursor_op_e op);
      cmd_valid = 1'b1;
      cmd_op = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_vblank();
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      tbl[0]  = '{int'(OP_SET), 100, 30, 79, 23};
      tbl[1]  = '{int'(OP_RIGHT), 0, 0, 79, 23};
      tbl[2]  = '{int'(OP_ADV),   0, 0, 79, 23};
      tbl[3]  = '{int'(OP_DOWN),  0, 0, 79, 23};
      tbl[4]  = '{int'(OP_HOME),  0, 0, 0, 0};
      tbl[5]  = '{int'(OP_LEFT),  0, 0, 0, 0};
      tbl[6]  = '{int'(OP_UP),    0, 0, 0, 0};
      tbl[7]  = '{int'(OP_TAB),   0, 0, 8, 0};
      tbl[8]  = '{int'(OP_SET),   7, 5, 7, 5};
      tbl[9]  = '{int'(OP_TAB),   0, 0, 8, 5};
      tbl[10] = '{int'(OP_TAB),   0, 0, 16, 5};
      tbl[11] = '{int'(OP_SET),  75, 5, 75, 5};
      tbl[12] = '{int'(OP_TAB),   0, 0, 79, 5};
      tbl[13] = '{int'(OP_CR),    0, 0, 0, 5};
      tbl[14] = '{int'(OP_DOWN),  0, 0, 0, 6};
      tbl[15] = '{int'(OP_RIGHT), 0, 0, 1, 6};
      tbl[16] = '{int'(OP_NOP),  50, 9, 1, 6};
      tbl[17] = '{13,            50, 9, 1, 6};
      tbl[18] = '{int'(OP_RI),    0, 0, 1, 5};
      tbl[19] = '{int'(OP_LF),    0, 0, 1, 6};
      tbl[20] = '{int'(OP_SET),   3, 22, 3, 22};
      tbl[21] = '{int'(OP_LF),    0, 0, 3, 23};

      reset = 1'b1; vblank = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
      cmd_x = '0; cmd_y = '0; mode = 2'd1; scroll_ack = 1'b0;
      tick();
      tick();
      chk("reset_x", int'(cursor_x), 0);
      chk("reset_y", int'(cursor_y), 0);
      chk("reset_visible", int'(cursor_visible), 0);
      chk("reset_led", int'(led), 0);
      reset = 1'b0;

      // constant vector table, back-to-back commands
      foreach (tbl[i]) begin
         cmd_valid = 1'b1;
         cmd_op = 4'(tbl[i].op);
         cmd_x = 7'(tbl[i].x);
         cmd_y = 5'(tbl[i].y);
         tick();
         chk($sformatf("vec%0d_x", i), int'(cursor_x), tbl[i].ex);
         chk($sformatf("vec%0d_y", i), int'(cursor_y), tbl[i].ey);
      end
      cmd_valid = 1'b0;
      chk("vec_no_scroll", int'(scroll_req), 0);

      // LF at bottom row: scroll request stalls a held CR until acknowledged
      issue(OP_LF);
      chk("lf_req", int'(scroll_req), 1);
      chk("lf_dir", int'(scroll_dir), 0);
      chk("lf_ready", int'(cmd_ready), 0);
      chk("lf_y", int'(cursor_y), 23);
      cmd_valid = 1'b1;
      cmd_op = OP_CR;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stalled_cr_x", int'(cursor_x), 3);
      end
      scroll_ack = 1'b1;
      tick();
      scroll_ack = 1'b0;
      chk("ack_req_drop", int'(scroll_req), 0);
      chk("ack_x_held", int'(cursor_x), 3);
      tick();
      cmd_valid = 1'b0;
      chk("cr_after_ack_x", int'(cursor_x), 0);

      scroll_ack = 1'b1;
      tick();
      scroll_ack = 1'b0;
      chk("idle_ack_ignored", int'(scroll_req), 0);

      // RI at top row, then reset before the acknowledge
      issue(OP_HOME);
      issue(OP_RI);
      chk("ri_req", int'(scroll_req), 1);
      chk("ri_dir", int'(scroll_dir), 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_scroll_req", int'(scroll_req), 0);
      chk("rst_mid_scroll_ready", int'(cmd_ready), 1);
      issue(OP_DOWN);
      chk("resume_after_reset_y", int'(cursor_y), 1);

      // blink: toggles every TB_BF vblank edges, movement restarts solid
      mode = 2'd0;
      issue(OP_RIGHT);
      tick();
      tick();
      chk("blink_start", int'(cursor_visible), 1);
      pulse_vblank();
      pulse_vblank();
      chk("blink_off", int'(cursor_visible), 0);
      pulse_vblank();
      pulse_vblank();
      chk("blink_on", int'(cursor_visible), 1);
      pulse_vblank();
      vblank = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = OP_RIGHT;
      tick();
      vblank = 1'b0;
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("collide_solid", int'(cursor_visible), 1);
      pulse_vblank();
      chk("collide_cnt_restart", int'(cursor_visible), 1);
      pulse_vblank();
      chk("collide_then_off", int'(cursor_visible), 0);

      // display modes and led trailing
      mode = 2'd2;
      tick();
      tick();
      chk("mode2_vis", int'(cursor_visible), 0);
      chk("mode2_led", int'(led), 0);
      mode = 2'd1;
      tick();
      chk("mode1_vis", int'(cursor_visible), 1);
      chk("led_trails", int'(led), 0);
      tick();
      chk("led_follows", int'(led), 1);
      pulse_vblank();
      pulse_vblank();
      chk("mode1_steady", int'(cursor_visible), 1);
      mode = 2'd3;
      tick();
      tick();
      chk("mode3_vis", int'(cursor_visible), 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         cmd_valid  = ($urandom_range(0, 3) != 0);
         cmd_op     = 4'($urandom_range(0, 15));
         cmd_x      = 7'($urandom_range(0, 127));
         cmd_y      = 5'($urandom_range(0, 31));
         vblank     = ($urandom_range(0, 2) == 0);
         scroll_ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
